// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin pipelined arbiter slice.
//   - Default bus field widths (address / data).
//   - Lock state encoding used by the arbiter's lock process.
//   - clog2 helper for master-ID and FIFO pointer widths.
//   - ARB_LANE(idx, w): part-select body for lane idx of a packed bus
//     with lanes of width w (usage: vec[`ARB_LANE(i, W)]).
// Related build macro: ARB_RR_PIPE_RESP_ERR_EN (enables err_o on the top).
// -----------------------------------------------------------------------------
`ifndef ARB_PKG_LANE_MACROS
`define ARB_PKG_LANE_MACROS
`define ARB_LANE(idx, w) ((idx) * (w)) +: (w)
`endif

package arb_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic {
      LK_FREE = 1'b0,
      LK_HELD = 1'b1
   } lock_state_e;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/arb_rr_pipe_if.sv
// -----------------------------------------------------------------------------
// arb_rr_pipe_if
// Bundles the per-master request bus (m_*) and the shared slave bus (s_*).
//   modport slave  : arbiter view (accepts master requests, drives slave bus)
//   modport master : environment view (masters + slave model)
// Lanes of m_addr/m_be/m_wdata/m_rdata are packed: master i at [i*W +: W].
// -----------------------------------------------------------------------------
interface arb_rr_pipe_if
   import arb_pkg::*;
#(
   parameter int unsigned NUM_M  = 4,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic [NUM_M-1:0]          m_req;
   logic [NUM_M-1:0]          m_we;
   logic [NUM_M*ADDR_W-1:0]   m_addr;
   logic [NUM_M*DATA_W/8-1:0] m_be;
   logic [NUM_M*DATA_W-1:0]   m_wdata;
   logic [NUM_M-1:0]          m_ack;
   logic [NUM_M-1:0]          m_resp;
   logic [NUM_M*DATA_W-1:0]   m_rdata;

   logic                      s_req;
   logic                      s_we;
   logic [ADDR_W-1:0]         s_addr;
   logic [DATA_W/8-1:0]       s_be;
   logic [DATA_W-1:0]         s_wdata;
   logic                      s_ack;
   logic                      s_resp;
   logic [DATA_W-1:0]         s_rdata;

   modport slave (
      input  m_req, m_we, m_addr, m_be, m_wdata,
      output m_ack, m_resp, m_rdata,
      output s_req, s_we, s_addr, s_be, s_wdata,
      input  s_ack, s_resp, s_rdata
   );

   modport master (
      output m_req, m_we, m_addr, m_be, m_wdata,
      input  m_ack, m_resp, m_rdata,
      input  s_req, s_we, s_addr, s_be, s_wdata,
      output s_ack, s_resp, s_rdata
   );
endinterface

// File: rtl/arb_rr_pipe_idfifo.sv
// -----------------------------------------------------------------------------
// arb_rr_pipe_idfifo
// Synchronous FIFO of master IDs for outstanding reads.
//   clk_i, rst_i : clock, synchronous active-high reset (to empty)
//   push_i/din_i : write an ID (ignored when full)
//   pop_i        : drop the head (ignored when empty)
//   dout_o       : head entry
//   full_o, empty_o : status
// Pointers carry one extra wrap bit: full when wrap bits differ and the
// index bits match.
// -----------------------------------------------------------------------------
module arb_rr_pipe_idfifo
   import arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_q, rd_q;
   logic [W-1:0]  mem_q [DEPTH];

   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && !full_o)  wr_q <= wr_q + PW'(1);
         if (pop_i  && !empty_o) rd_q <= rd_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/arb_rr_pipe.sv
// -----------------------------------------------------------------------------
// arb_rr_pipe
// Round-robin arbiter sharing one slave port among NUM_M masters, with up to
// RD_DEPTH reads outstanding; read responses return in issue order and are
// steered back to the issuing master through an ID FIFO.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active high
//   bus   : arb_rr_pipe_if.slave (m_* master lanes, s_* shared slave bus)
//   err_o : sticky spurious-response flag; present only when the build macro
//           ARB_RR_PIPE_RESP_ERR_EN is defined
// -----------------------------------------------------------------------------
module arb_rr_pipe
   import arb_pkg::*;
#(
   parameter int unsigned NUM_M    = 4,
   parameter int unsigned RD_DEPTH = 4,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   arb_rr_pipe_if.slave  bus
`ifdef ARB_RR_PIPE_RESP_ERR_EN
   ,
   output logic          err_o
`endif
);
   localparam int unsigned ID_W = clog2(NUM_M);
   localparam int unsigned BE_W = DATA_W / 8;

   lock_state_e       lock_q, lock_d;
   logic [ID_W-1:0]   lock_id_q, lock_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic              gnt_vld;
   logic [ID_W-1:0]   gnt_id;
   logic              hs, push, pop, full, empty;
   logic [ID_W-1:0]   head_id;

   logic [ADDR_W-1:0] addr_a  [NUM_M];
   logic [BE_W-1:0]   be_a    [NUM_M];
   logic [DATA_W-1:0] wdata_a [NUM_M];

   // Unpack master lanes; steer responses to the FIFO head's lane.
   for (genvar i = 0; i < NUM_M; i++) begin : g_lane
      assign addr_a[i]  = bus.m_addr[`ARB_LANE(i, ADDR_W)];
      assign be_a[i]    = bus.m_be[`ARB_LANE(i, BE_W)];
      assign wdata_a[i] = bus.m_wdata[`ARB_LANE(i, DATA_W)];
      assign bus.m_resp[i] = pop && (head_id == ID_W'(i));
      assign bus.m_rdata[`ARB_LANE(i, DATA_W)] =
         (pop && (head_id == ID_W'(i))) ? bus.s_rdata : '0;
   end

   // Grant selection. A full FIFO blocks all issue, using only registered
   // state so s_resp never feeds s_req combinationally.
   always_comb begin
      int unsigned     idx;
      logic [ID_W-1:0] cand;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      cand    = '0;
      if (!full) begin
         if (lock_q == LK_HELD) begin
            gnt_id  = lock_id_q;
            gnt_vld = bus.m_req[lock_id_q];
         end else begin
            for (int unsigned k = 0; k < NUM_M; k++) begin
               idx  = (32'(rr_ptr_q) + k) % NUM_M;
               cand = ID_W'(idx);
               if (!gnt_vld && bus.m_req[cand]) begin
                  gnt_vld = 1'b1;
                  gnt_id  = cand;
               end
            end
         end
      end
   end

   always_comb begin
      bus.s_req   = gnt_vld;
      bus.s_we    = 1'b0;
      bus.s_addr  = '0;
      bus.s_be    = '0;
      bus.s_wdata = '0;
      bus.m_ack   = '0;
      if (gnt_vld) begin
         bus.s_we            = bus.m_we[gnt_id];
         bus.s_addr          = addr_a[gnt_id];
         bus.s_be            = be_a[gnt_id];
         bus.s_wdata         = wdata_a[gnt_id];
         bus.m_ack[gnt_id]   = bus.s_ack;
      end
   end

   assign hs   = gnt_vld && bus.s_ack;
   assign push = hs && !bus.m_we[gnt_id];
   assign pop  = bus.s_resp && !empty;

   // Lock / round-robin pointer next state. A stalled request locks the grant;
   // a locked master dropping req leaves the lock held.
   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      rr_ptr_d  = rr_ptr_q;
      if (hs) begin
         lock_d   = LK_FREE;
         rr_ptr_d = ID_W'((32'(gnt_id) + 1) % NUM_M);
      end else if (gnt_vld) begin
         lock_d    = LK_HELD;
         lock_id_d = gnt_id;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q    <= LK_FREE;
         lock_id_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   arb_rr_pipe_idfifo #(
      .DEPTH (RD_DEPTH),
      .W     (ID_W)
   ) u_idfifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (gnt_id),
      .dout_o  (head_id),
      .full_o  (full),
      .empty_o (empty)
   );

`ifdef ARB_RR_PIPE_RESP_ERR_EN
   logic err_q;
   always_ff @(posedge clk_i) begin
      if (rst_i)                      err_q <= 1'b0;
      else if (bus.s_resp && empty)   err_q <= 1'b1;
   end
   assign err_o = err_q;
`endif
endmodule
